// File: rtl/hazard_pkg.sv
// Shared encodings and shadow-pipeline entry type for the hazard/forwarding controller.
package hazard_pkg;

  localparam int unsigned FWD_W = 2;
  localparam int unsigned CNT_W = 16;
  // Widest register address supported; narrower addresses are zero-extended into it.
  localparam int unsigned DST_W = 8;

  localparam logic [FWD_W-1:0] FWD_RF   = 2'd0;
  localparam logic [FWD_W-1:0] FWD_MEM  = 2'd1;
  localparam logic [FWD_W-1:0] FWD_WB   = 2'd2;
  localparam logic [FWD_W-1:0] FWD_HOLD = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [DST_W-1:0] dst;
    logic             reg_write;
    logic             mem_read;
  } shadow_t;

  // A live writer of a nonzero register that this operand actually reads.
  function automatic logic entry_hit(shadow_t e, logic [DST_W-1:0] src, logic used);
    return used && e.valid && e.reg_write && (e.dst == src) && (src != '0);
  endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// One source operand: load-use detection for ID and forward select/data mux for EX.
module fwd_operand_mux
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic              en_i,
  input  logic [REG_AW-1:0] id_src_i,
  input  logic              id_used_i,
  input  logic [REG_AW-1:0] ex_src_i,
  input  logic              ex_used_i,
  input  shadow_t           ex_e_i,
  input  shadow_t           mem_e_i,
  input  shadow_t           wb_e_i,
  input  shadow_t           hold_e_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic [XLEN-1:0]   hold_data_i,
  output logic              load_hit_o,
  output logic [FWD_W-1:0]  sel_o,
  output logic [XLEN-1:0]   data_o
);

  logic [DST_W-1:0] id_src;
  logic [DST_W-1:0] ex_src;

  assign id_src = DST_W'(id_src_i);
  assign ex_src = DST_W'(ex_src_i);

  // Newest producer wins; a load still in MEM has no data yet and is skipped.
  always_comb begin
    load_hit_o = 1'b0;
    sel_o      = FWD_RF;
    if (en_i) begin
      load_hit_o = entry_hit(ex_e_i, id_src, id_used_i) && ex_e_i.mem_read;
      if (LOAD_LAT >= 2) begin
        load_hit_o = load_hit_o || (entry_hit(mem_e_i, id_src, id_used_i) && mem_e_i.mem_read);
      end
      if (entry_hit(mem_e_i, ex_src, ex_used_i) && !mem_e_i.mem_read) begin
        sel_o = FWD_MEM;
      end else if (entry_hit(wb_e_i, ex_src, ex_used_i)) begin
        sel_o = FWD_WB;
      end else if (entry_hit(hold_e_i, ex_src, ex_used_i)) begin
        sel_o = FWD_HOLD;
      end
    end
  end

  always_comb begin
    data_o = rf_data_i;
    case (sel_o)
      FWD_MEM:  data_o = mem_data_i;
      FWD_WB:   data_o = wb_data_i;
      FWD_HOLD: data_o = hold_data_i;
      default:  data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and operand forwarding for the 5-stage pipeline, with a
// shadow scoreboard of EX/MEM/WB/WB+1 destinations and stall/flush counters.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst_addr,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      branch_taken,
  input  logic [NUM_SRC*XLEN-1:0]   ex_rf_data,
  input  logic [XLEN-1:0]           mem_alu_result,
  input  logic [XLEN-1:0]           wb_data,
  output logic                      stall,
  output logic                      bubble_ex,
  output logic                      flush_if,
  output logic [NUM_SRC*FWD_W-1:0]  fwd_sel,
  output logic [NUM_SRC*XLEN-1:0]   ex_src_data,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  shadow_t                   ex_q, ex_d, mem_q, wb_q, hold_e_q;
  logic [NUM_SRC*REG_AW-1:0] ex_src_q, ex_src_d;
  logic [NUM_SRC-1:0]        ex_used_q, ex_used_d;
  logic [XLEN-1:0]           hold_data_q, hold_data_d;
  logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]          flush_cnt_q, flush_cnt_d;
  logic [NUM_SRC-1:0]        load_hit;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_operand_mux #(
      .REG_AW   (REG_AW),
      .XLEN     (XLEN),
      .LOAD_LAT (LOAD_LAT)
    ) u_mux (
      .en_i        (rst_n),
      .id_src_i    (id_src_addr[g*REG_AW +: REG_AW]),
      .id_used_i   (id_src_used[g]),
      .ex_src_i    (ex_src_q[g*REG_AW +: REG_AW]),
      .ex_used_i   (ex_used_q[g]),
      .ex_e_i      (ex_q),
      .mem_e_i     (mem_q),
      .wb_e_i      (wb_q),
      .hold_e_i    (hold_e_q),
      .rf_data_i   (ex_rf_data[g*XLEN +: XLEN]),
      .mem_data_i  (mem_alu_result),
      .wb_data_i   (wb_data),
      .hold_data_i (hold_data_q),
      .load_hit_o  (load_hit[g]),
      .sel_o       (fwd_sel[g*FWD_W +: FWD_W]),
      .data_o      (ex_src_data[g*XLEN +: XLEN])
    );
  end

  // A taken branch overrides any load-use stall; everything is quiet in reset.
  always_comb begin
    stall     = rst_n && !branch_taken && (|load_hit);
    bubble_ex = rst_n && (branch_taken || stall);
    flush_if  = rst_n && branch_taken;
  end

  always_comb begin
    ex_d        = '0;
    ex_src_d    = '0;
    ex_used_d   = '0;
    hold_data_d = hold_data_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_valid && !stall && !branch_taken) begin
      ex_d.valid     = 1'b1;
      ex_d.dst       = DST_W'(id_dst_addr);
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_src_d       = id_src_addr;
      ex_used_d      = id_src_used;
    end
    if (wb_q.valid && wb_q.reg_write) begin
      hold_data_d = wb_data;
    end
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (branch_taken && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      hold_e_q    <= '0;
      ex_src_q    <= '0;
      ex_used_q   <= '0;
      hold_data_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      hold_e_q    <= wb_q;
      ex_src_q    <= ex_src_d;
      ex_used_q   <= ex_used_d;
      hold_data_q <= hold_data_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed scenarios plus random streams on a
// LOAD_LAT=1 instance (index 0) and a LOAD_LAT=2 instance (index 1).
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid       [2];
  logic [9:0]  id_src_addr    [2];
  logic [1:0]  id_src_used    [2];
  logic [4:0]  id_dst_addr    [2];
  logic        id_reg_write   [2];
  logic        id_mem_read    [2];
  logic        branch_taken   [2];
  logic [63:0] ex_rf_data     [2];
  logic [31:0] mem_alu_result [2];
  logic [31:0] wb_data        [2];
  logic        stall          [2];
  logic        bubble_ex      [2];
  logic        flush_if       [2];
  logic [3:0]  fwd_sel        [2];
  logic [63:0] ex_src_data    [2];
  logic [15:0] stall_cnt      [2];
  logic [15:0] flush_cnt      [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_AW(5), .XLEN(32), .NUM_SRC(2), .LOAD_LAT(1)) u_dut_ll1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid[0]), .id_src_addr(id_src_addr[0]),
    .id_src_used(id_src_used[0]), .id_dst_addr(id_dst_addr[0]), .id_reg_write(id_reg_write[0]),
    .id_mem_read(id_mem_read[0]), .branch_taken(branch_taken[0]), .ex_rf_data(ex_rf_data[0]),
    .mem_alu_result(mem_alu_result[0]), .wb_data(wb_data[0]), .stall(stall[0]),
    .bubble_ex(bubble_ex[0]), .flush_if(flush_if[0]), .fwd_sel(fwd_sel[0]),
    .ex_src_data(ex_src_data[0]), .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
  );

  hazard_forward_ctrl #(.REG_AW(5), .XLEN(32), .NUM_SRC(2), .LOAD_LAT(2)) u_dut_ll2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid[1]), .id_src_addr(id_src_addr[1]),
    .id_src_used(id_src_used[1]), .id_dst_addr(id_dst_addr[1]), .id_reg_write(id_reg_write[1]),
    .id_mem_read(id_mem_read[1]), .branch_taken(branch_taken[1]), .ex_rf_data(ex_rf_data[1]),
    .mem_alu_result(mem_alu_result[1]), .wb_data(wb_data[1]), .stall(stall[1]),
    .bubble_ex(bubble_ex[1]), .flush_if(flush_if[1]), .fwd_sel(fwd_sel[1]),
    .ex_src_data(ex_src_data[1]), .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
  );

  // Reference model: the last four issue slots, slot k = k stages past EX.
  typedef struct packed {
    logic        v;
    logic        rw;
    logic        mr;
    logic [4:0]  dst;
    logic [9:0]  src;
    logic [1:0]  used;
    logic [31:0] wbval;
  } ins_t;

  ins_t hist [2][4];
  int   m_stall_cnt [2];
  int   m_flush_cnt [2];

  function automatic bit writes(ins_t e, logic [4:0] r);
    return e.v && e.rw && (r != 5'd0) && (e.dst == r);
  endfunction

  // Stall while a load that has not yet produced data writes a register ID reads.
  function automatic bit exp_stall(int d);
    logic [4:0] s;
    if (!rst_n || branch_taken[d]) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = id_src_addr[d][i*5 +: 5];
      if (id_src_used[d][i]) begin
        for (int k = 0; k <= d; k++) begin
          if (writes(hist[d][k], s) && hist[d][k].mr) return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  // Forward from the closest older instruction writing the EX operand.
  function automatic logic [1:0] exp_sel(int d, int i);
    logic [4:0] s;
    s = hist[d][0].src[i*5 +: 5];
    if (!rst_n || !hist[d][0].used[i]) return 2'd0;
    for (int k = 1; k < 4; k++) begin
      if (writes(hist[d][k], s) && !(k == 1 && hist[d][k].mr)) return 2'(k);
    end
    return 2'd0;
  endfunction

  function automatic logic [31:0] exp_data(int d, int i, logic [1:0] s);
    case (s)
      2'd1:    return mem_alu_result[d];
      2'd2:    return wb_data[d];
      2'd3:    return hist[d][3].wbval;
      default: return ex_rf_data[d][i*32 +: 32];
    endcase
  endfunction

  task automatic model_step(int d);
    ins_t n;
    bit   st;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) hist[d][k] = '0;
      m_stall_cnt[d] = 0;
      m_flush_cnt[d] = 0;
    end else begin
      st = exp_stall(d);
      if (st && m_stall_cnt[d] < 65535) m_stall_cnt[d]++;
      if (branch_taken[d] && m_flush_cnt[d] < 65535) m_flush_cnt[d]++;
      hist[d][2].wbval = wb_data[d];
      for (int k = 3; k > 0; k--) hist[d][k] = hist[d][k-1];
      n = '0;
      if (id_valid[d] && !st && !branch_taken[d]) begin
        n.v = 1'b1; n.rw = id_reg_write[d]; n.mr = id_mem_read[d];
        n.dst = id_dst_addr[d]; n.src = id_src_addr[d]; n.used = id_src_used[d];
      end
      hist[d][0] = n;
    end
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) model_step(d);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int d, bit v, int s0, int s1, int used, int dst, bit rw, bit mr);
    id_valid[d]     = v;
    id_src_addr[d]  = {5'(s1), 5'(s0)};
    id_src_used[d]  = 2'(used);
    id_dst_addr[d]  = 5'(dst);
    id_reg_write[d] = rw;
    id_mem_read[d]  = mr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 0, 0, 0, 0, 0, 0);
      branch_taken[d] = 1'b0; ex_rf_data[d] = '0;
      mem_alu_result[d] = '0; wb_data[d] = '0;
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      drive(d, 1, 3, 3, 3, 3, 1, 1);
      branch_taken[d] = 1'b1;
      ex_rf_data[d] = {$urandom, $urandom};
    end
    tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({stall[d], bubble_ex[d], flush_if[d]} !== 3'b000) begin
        failures++; $display("FAIL reset_ctrl d%0d: got %b want 000", d, {stall[d], bubble_ex[d], flush_if[d]});
      end
      checks++;
      if (fwd_sel[d] !== 4'd0 || ex_src_data[d] !== ex_rf_data[d]) begin
        failures++; $display("FAIL reset_fwd d%0d: got sel %h data %h want 0 / %h", d, fwd_sel[d], ex_src_data[d], ex_rf_data[d]);
      end
      checks++;
      if (stall_cnt[d] !== 16'd0 || flush_cnt[d] !== 16'd0) begin
        failures++; $display("FAIL reset_cnt d%0d: got %h/%h want 0/0", d, stall_cnt[d], flush_cnt[d]);
      end
    end
  endtask

  task automatic test_mem_forward();
    do_reset();
    drive(0, 1, 0, 0, 0, 1, 1, 0);
    tick();
    drive(0, 1, 1, 1, 3, 2, 1, 0);
    #1;
    checks++;
    if (stall[0] !== 1'b0) begin
      failures++; $display("FAIL memfwd_stall: got %b want 0", stall[0]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    mem_alu_result[0] = 32'h5;
    ex_rf_data[0] = {32'h1111_1111, 32'h2222_2222};
    #1;
    checks++;
    if (fwd_sel[0] !== 4'b0101) begin
      failures++; $display("FAIL memfwd_sel: got %b want 0101", fwd_sel[0]);
    end
    checks++;
    if (ex_src_data[0] !== {32'h5, 32'h5}) begin
      failures++; $display("FAIL memfwd_data: got %h want %h", ex_src_data[0], {32'h5, 32'h5});
    end
  endtask

  task automatic test_load_use(int d, bit gap, int exp_stalls, logic [1:0] esel);
    int n;
    do_reset();
    wb_data[d] = 32'hDEAD;
    drive(d, 1, 0, 0, 0, 3, 1, 1);
    tick();
    if (gap) begin
      drive(d, 1, 0, 0, 0, 5, 1, 0);
      tick();
    end
    drive(d, 1, 3, 0, 3, 4, 1, 0);
    ex_rf_data[d] = {32'hAAAA_0001, 32'hAAAA_0000};
    #1;
    n = 0;
    while (stall[d] === 1'b1 && n < 8) begin
      checks++;
      if (bubble_ex[d] !== 1'b1) begin
        failures++; $display("FAIL lu_bubble d%0d: got %b want 1", d, bubble_ex[d]);
      end
      n++;
      tick();
      #1;
    end
    checks++;
    if (n != exp_stalls) begin
      failures++; $display("FAIL lu_stalls d%0d gap%0d: got %0d want %0d", d, gap, n, exp_stalls);
    end
    tick();
    drive(d, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (fwd_sel[d] !== {2'd0, esel}) begin
      failures++; $display("FAIL lu_sel d%0d gap%0d: got %b want %b", d, gap, fwd_sel[d], {2'd0, esel});
    end
    checks++;
    if (ex_src_data[d] !== {32'hAAAA_0001, 32'hDEAD}) begin
      failures++; $display("FAIL lu_data d%0d: got %h want %h", d, ex_src_data[d], {32'hAAAA_0001, 32'hDEAD});
    end
    checks++;
    if (stall_cnt[d] !== 16'(exp_stalls)) begin
      failures++; $display("FAIL lu_cnt d%0d: got %0d want %0d", d, stall_cnt[d], exp_stalls);
    end
  endtask

  task automatic test_r0();
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 1, 1);
    tick();
    drive(0, 1, 0, 0, 3, 7, 1, 0);
    mem_alu_result[0] = 32'h99;
    ex_rf_data[0] = {32'h0BAD_0001, 32'h0BAD_0000};
    #1;
    checks++;
    if (stall[0] !== 1'b0) begin
      failures++; $display("FAIL r0_stall: got %b want 0", stall[0]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (fwd_sel[0] !== 4'd0 || ex_src_data[0] !== {32'h0BAD_0001, 32'h0BAD_0000}) begin
      failures++; $display("FAIL r0_fwd: got sel %b data %h want 0000 / 0bad00010bad0000", fwd_sel[0], ex_src_data[0]);
    end
  endtask

  task automatic test_branch_loaduse();
    do_reset();
    drive(0, 1, 0, 0, 0, 3, 1, 1);
    tick();
    drive(0, 1, 3, 0, 1, 4, 1, 0);
    branch_taken[0] = 1'b1;
    #1;
    checks++;
    if ({flush_if[0], bubble_ex[0], stall[0]} !== 3'b110) begin
      failures++; $display("FAIL br_ctrl: got %b want 110", {flush_if[0], bubble_ex[0], stall[0]});
    end
    tick();
    branch_taken[0] = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (flush_cnt[0] !== 16'd1 || stall_cnt[0] !== 16'd0) begin
      failures++; $display("FAIL br_cnt: got flush %0d stall %0d want 1/0", flush_cnt[0], stall_cnt[0]);
    end
  endtask

  task automatic test_distance3_and_reset();
    do_reset();
    drive(0, 1, 0, 0, 0, 6, 1, 0);
    tick();
    drive(0, 1, 0, 0, 0, 8, 1, 0);
    tick();
    drive(0, 1, 0, 0, 0, 9, 1, 0);
    tick();
    drive(0, 1, 6, 0, 1, 10, 1, 0);
    wb_data[0] = 32'h1234;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wb_data[0] = 32'hBEEF;
    ex_rf_data[0] = {32'h7777_0001, 32'h7777_0000};
    #1;
    checks++;
    if (fwd_sel[0] !== 4'b0011 || ex_src_data[0][31:0] !== 32'h1234) begin
      failures++; $display("FAIL dist3: got sel %b data %h want 0011 / 1234", fwd_sel[0], ex_src_data[0][31:0]);
    end
    tick();
    drive(0, 1, 0, 0, 0, 3, 1, 1);
    tick();
    drive(0, 1, 3, 3, 3, 4, 1, 0);
    #1;
    checks++;
    if (stall[0] !== 1'b1) begin
      failures++; $display("FAIL midstall_pre: got %b want 1", stall[0]);
    end
    rst_n = 1'b0;
    tick();
    #1;
    checks++;
    if ({stall[0], bubble_ex[0], flush_if[0]} !== 3'b000 || fwd_sel[0] !== 4'd0 ||
        ex_src_data[0] !== ex_rf_data[0] || stall_cnt[0] !== 16'd0 || flush_cnt[0] !== 16'd0) begin
      failures++; $display("FAIL midstall_rst: got ctrl %b sel %b cnt %0d/%0d want 000 0000 0/0",
                           {stall[0], bubble_ex[0], flush_if[0]}, fwd_sel[0], stall_cnt[0], flush_cnt[0]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit         held [2];
    bit         es;
    bit         v;
    logic [1:0] s;
    do_reset();
    held[0] = 1'b0; held[1] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_n = ($urandom % 60) != 0;
      for (int d = 0; d < 2; d++) begin
        if (!held[d]) begin
          v = ($urandom % 8) != 0;
          drive(d, v, $urandom % 4, $urandom % 4, v ? ($urandom % 4) : 0,
                $urandom % 4, ($urandom % 4) != 0, ($urandom % 3) == 0);
        end
        branch_taken[d]   = ($urandom % 8) == 0;
        ex_rf_data[d]     = {$urandom, $urandom};
        mem_alu_result[d] = $urandom;
        wb_data[d]        = $urandom;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        es = exp_stall(d);
        checks++;
        if ({stall[d], bubble_ex[d], flush_if[d]} !== {es, rst_n && (es || branch_taken[d]), rst_n && branch_taken[d]}) begin
          failures++; $display("FAIL rnd_ctrl d%0d cyc%0d: got %b want %b", d, cyc, {stall[d], bubble_ex[d], flush_if[d]},
                               {es, rst_n && (es || branch_taken[d]), rst_n && branch_taken[d]});
        end
        for (int i = 0; i < 2; i++) begin
          s = exp_sel(d, i);
          checks++;
          if (fwd_sel[d][i*2 +: 2] !== s || ex_src_data[d][i*32 +: 32] !== exp_data(d, i, s)) begin
            failures++; $display("FAIL rnd_fwd d%0d op%0d cyc%0d: got %0d/%h want %0d/%h", d, i, cyc,
                                 fwd_sel[d][i*2 +: 2], ex_src_data[d][i*32 +: 32], s, exp_data(d, i, s));
          end
        end
        held[d] = es;
      end
      tick();
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0, 0, 0);
    branch_taken[0] = 1'b0; branch_taken[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (stall_cnt[d] !== 16'(m_stall_cnt[d]) || flush_cnt[d] !== 16'(m_flush_cnt[d])) begin
        failures++; $display("FAIL rnd_cnt d%0d: got %0d/%0d want %0d/%0d", d, stall_cnt[d], flush_cnt[d],
                             m_stall_cnt[d], m_flush_cnt[d]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_mem_forward();
    test_load_use(0, 1'b0, 1, 2'd2);
    test_load_use(1, 1'b0, 2, 2'd3);
    test_load_use(1, 1'b1, 1, 2'd3);
    test_r0();
    test_branch_loaduse();
    test_distance3_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised hazard-detection and operand-forwarding controller for the in-order 5-stage pipeline (IF/ID/EX/MEM/WB). It keeps its own shadow scoreboard of in-flight destination registers across EX/MEM/WB/WB+1. From that scoreboard it generates the IF/ID hold, the ID/EX bubble and flushes on a taken branch, and it muxes forwarded operand data into EX. It generalises the fixed two-operand, single-load-bubble unit to N source operands, configurable load latency and distance-3 forwarding, and adds stall/flush statistics counters.

## Interface
- REG_AW, 5, register address width
- XLEN, 32, datapath width
- NUM_SRC, 2, source operands per instruction (1..3)
- LOAD_LAT, 1, load result availability: 1 = end of MEM, 2 = end of WB
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_src_addr  in  NUM_SRC*REG_AW  source register addresses in ID; operand i occupies slice i
- id_src_used  in  NUM_SRC  operand i is actually read
- id_dst_addr  in  REG_AW  destination register of the ID instruction
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- branch_taken  in  1  branch resolved taken in EX this cycle
- ex_rf_data  in  NUM_SRC*XLEN  register-file operands latched in ID/EX
- mem_alu_result  in  XLEN  ALU result in EX/MEM
- wb_data  in  XLEN  final write-back value in MEM/WB
- stall  out  1  hold PC and IF/ID
- bubble_ex  out  1  load a NOP into ID/EX
- flush_if  out  1  kill the IF/ID contents
- fwd_sel  out  NUM_SRC*2  per operand: 0 RF, 1 MEM, 2 WB, 3 WB+1 hold
- ex_src_data  out  NUM_SRC*XLEN  forwarded operands to the ALU
- stall_cnt  out  16  saturating count of stall cycles
- flush_cnt  out  16  saturating count of flush events

## Operation
- **Shadow stages.** EX, MEM, WB and WB+1 each hold {valid, dst, reg_write, mem_read}. Every cycle the entries shift one stage. EX loads the ID info when id_valid & ~stall & ~branch_taken; otherwise EX loads a bubble (valid=0).
- **WB+1 data hold.** An XLEN register captures wb_data whenever the WB shadow is valid with reg_write=1. This covers the distance-3 read/write overlap without a write-through register file.
- **Match rule.** For operand i and stage S: match = id_src_used[i] & S.valid & S.reg_write & (S.dst == src) & (src != 0). Register 0 never matches.
- **Load-use stall.**
  - Stall when any operand matches an EX entry with mem_read=1.
  - When LOAD_LAT=2, also stall when any operand matches a MEM entry with mem_read=1.
- **Forward select.** Computed per operand against the EX instruction's sources, which are registered alongside the EX shadow. The newest match wins:
  - MEM entry, non-load only: select 1.
  - WB entry: select 2.
  - WB+1 entry: select 3.
  - No match: select 0.
- **Forward data.** ex_src_data slice i = mux(fwd_sel[i]) over {ex_rf_data[i], mem_alu_result, wb_data, hold}.
- **Branch.** branch_taken forces flush_if=1, bubble_ex=1, stall=0 in the same cycle. Flush wins over a simultaneous stall.
- **Counters.** stall_cnt increments on each cycle with stall=1. flush_cnt increments on each cycle with branch_taken=1. Both saturate at 0xFFFF.

## Timing
- stall, bubble_ex, flush_if, fwd_sel and ex_src_data are combinational from inputs and registered shadow state; there is no added latency.
- Load-use penalty: 1 bubble when LOAD_LAT=1; 2 bubbles when LOAD_LAT=2 and the consumer immediately follows the load, 1 bubble when one instruction separates them.
- During a stall, stall and bubble_ex are both 1. The ID instruction is re-evaluated every cycle; the stall ends in the first cycle with no blocking match.
- Reset, including mid-stall or mid-flush: at the first clk edge with rst_n=0, all shadow valids, the hold register and both counters clear. The combinational outputs below are held at these values in every cycle where rst_n=0:
  - stall=0, bubble_ex=0, flush_if=0, fwd_sel=0, ex_src_data=ex_rf_data.
- Simultaneous events:
  - Load-use plus branch_taken: flush only; stall_cnt does not increment.
  - Two stages match the same register: the newest stage wins.

## Structure
- A shared package hazard_pkg holds the fwd_sel encodings (FWD_RF, FWD_MEM, FWD_WB, FWD_HOLD) and the shadow-entry struct typedef.
- One sub-module, fwd_operand_mux, is instantiated NUM_SRC times via generate. Each instance contains one operand's match logic and its 4:1 data mux.

## Test plan
- add r1 (MEM holds mem_alu_result=0x5), then add r2,r1,r1 in EX -> fwd_sel=1 on both operands, ex_src_data=0x5 on both, stall=0.
- LOAD_LAT=1: lw r3 directly followed by add r4,r3,r0 -> exactly 1 stall cycle, then fwd_sel[0]=2 with wb_data=0xDEAD; stall_cnt=1.
- LOAD_LAT=2, same sequence -> 2 stall cycles; with one independent instruction between the load and the consumer -> 1 stall cycle.
- Destination r0 followed by a consumer of r0 -> fwd_sel=0, stall=0.
- Load-use hazard coincident with branch_taken -> flush_if=1, bubble_ex=1, stall=0; flush_cnt=1, stall_cnt=0.
- Producer at distance 3 with wb_data=0x1234 captured -> fwd_sel=3 and ex_src_data=0x1234; asserting rst_n=0 mid-stall -> all outputs at reset values at the next edge, counters 0.
